exe_stage: RTL
==============

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage pipeline, directly downstream of the decode stage.
//  - Latches the decoded instruction bus and evaluates the 12-op ALU.
//  - Issues the data-SRAM request for ld.w / st.w.
//  - Forwards the result bundle to the memory stage.
//  - Returns {write-enable, dest} to decode so decode can detect hazards and stall.
// PARAMETERS
//  DS_TO_ES_BUS_WD  150  width of the input instruction bus
//  ES_TO_MS_BUS_WD  71   width of the output bus to the memory stage
//  ES_TO_ID_BUS_WD  6    width of the hazard-info bus back to decode
// PORTS
//  clk             in   1    clock
//  reset           in   1    synchronous, active-high reset
//  ms_allowin      in   1    memory stage can accept this cycle
//  es_allowin      out  1    this stage can accept this cycle
//  ds_to_es_valid  in   1    decode presents a valid instruction
//  ds_to_es_bus    in   150  alu_op[149:138] load_op[137] src1_is_pc[136] src2_is_imm[135]
//                            gr_we[134] mem_we[133] dest[132:128] imm[127:96]
//                            rj_value[95:64] rkd_value[63:32] pc[31:0]
//  es_to_ms_valid  out  1    valid toward the memory stage
//  es_to_ms_bus    out  71   res_from_mem[70] gr_we[69] dest[68:64] alu_result[63:32] pc[31:0]
//  es_to_id_bus    out  6    {es_rf_wen, es_rf_dest[4:0]}
//  data_sram_en    out  1    data SRAM access strobe
//  data_sram_we    out  4    byte write enables
//  data_sram_addr  out  32   byte address (= alu_result)
//  data_sram_wdata out  32   store data (= rkd_value)
// BEHAVIOUR
//  Handshake and state
//  - es_ready_go = 1 (single-cycle execute).
//  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
//  - es_to_ms_valid = es_valid && es_ready_go.
//  - On a clock edge with es_allowin = 1: es_valid <= ds_to_es_valid.
//    If ds_to_es_valid is also 1, the bus register <= ds_to_es_bus.
//  - With es_allowin = 0, the bus register and es_valid hold, so the instruction is
//    stable under ms_allowin = 0 backpressure.
//  - Reset: es_valid = 0 and bus register = 0. Hence es_allowin = 1, es_to_ms_valid = 0,
//    es_to_id_bus = 0, data_sram_en = 0 and data_sram_we = 0.
//  - Reset asserted mid-operation drops the held instruction; no SRAM strobe is issued
//    in that cycle.
//  ALU
//  - src1 = src1_is_pc ? pc : rj_value.
//  - src2 = src2_is_imm ? imm : rkd_value.
//  - alu_op is one-hot. Bit: 0 add, 1 sub, 2 slt (signed), 3 sltu, 4 and, 5 nor, 6 or,
//    7 xor, 8 sll, 9 srl, 10 sra, 11 lui.
//  - Shift amount = src2[4:0]. lui result = {src2[19:0], 12'b0}.
//  - Add and sub wrap modulo 2^32. slt and sltu return 32'd0 or 32'd1.
//  - alu_op all-zero gives result 0.
//  - Result is combinational from the bus register; execute latency is 1 cycle.
//  Memory
//  - data_sram_en = es_valid && (load_op || mem_we) && ms_allowin.
//    The strobe fires only in the hand-off cycle, so each access is issued exactly once
//    under backpressure.
//  - data_sram_we = {4{es_valid && mem_we && ms_allowin}}.
//  - addr = alu_result. No alignment check; the low 2 bits pass through.
//  Outputs
//  - es_to_id_bus = {es_valid && gr_we, dest}. The wen bit is 0 whenever es_valid = 0.
//  - es_to_ms_bus.res_from_mem = load_op.
// TESTING
//  1. Reset 3 cycles, then release -> es_allowin = 1; es_to_ms_valid, data_sram_en and
//     es_to_id_bus are all 0.
//  2. add.w rj = 5, rk = 7, dest = 3, ms_allowin = 1 -> next cycle es_to_ms_valid = 1,
//     alu_result = 12, es_to_id_bus = 6'b1_00011.
//  3. sra rj = 32'h8000_0000, imm = 4 (src2_is_imm) -> result 32'hF800_0000.
//     slt -1 vs 1 -> 1; sltu -1 vs 1 -> 0.
//  4. st.w rj = 32'h100, imm = 8, rkd = 32'hDEAD_BEEF, ms_allowin = 0 for 3 cycles then 1
//     -> es_allowin = 0 and en = 0 while stalled. en = 1, we = 4'hF, addr = 32'h108,
//     wdata = 32'hDEADBEEF for exactly 1 cycle.
//  5. bl with pc = 32'h1C00_0010, imm = 4 -> result 32'h1C00_0014, dest = 1,
//     gr_we = 1, no SRAM strobe.
//  6. Assert reset while a load is held by ms_allowin = 0 -> es_valid = 0 on the next
//     cycle, no data_sram_en pulse, es_to_id_bus wen = 0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: latches the decoded instruction, evaluates the ALU, issues the
// data-SRAM access for ld.w/st.w, and forwards results to memory and hazard info to decode.
module exe_stage #(
  parameter int unsigned DS_TO_ES_BUS_WD = 150,
  parameter int unsigned ES_TO_MS_BUS_WD = 71,
  parameter int unsigned ES_TO_ID_BUS_WD = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_ID_BUS_WD-1:0] es_to_id_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  localparam int unsigned ALU_OP_WD = 12;
  localparam int unsigned XLEN      = 32;

  logic                       es_valid;
  logic                       es_ready_go;
  logic [DS_TO_ES_BUS_WD-1:0] es_bus_r;

  logic [ALU_OP_WD-1:0] alu_op;
  logic                 load_op;
  logic                 src1_is_pc;
  logic                 src2_is_imm;
  logic                 gr_we;
  logic                 mem_we;
  logic [4:0]           dest;
  logic [XLEN-1:0]      imm;
  logic [XLEN-1:0]      rj_value;
  logic [XLEN-1:0]      rkd_value;
  logic [XLEN-1:0]      pc;

  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_result;

  assign {alu_op, load_op, src1_is_pc, src2_is_imm, gr_we, mem_we, dest,
          imm, rj_value, rkd_value, pc} = es_bus_r;

  // Handshake: single-cycle execute, hold under memory-stage backpressure
  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
      es_bus_r <= '0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) begin
        es_bus_r <= ds_to_es_bus;
      end
    end
  end

  assign src1  = src1_is_pc  ? pc  : rj_value;
  assign src2  = src2_is_imm ? imm : rkd_value;
  assign shamt = src2[4:0];

  // One-hot AND-OR select; an all-zero op vector yields zero
  always_comb begin
    alu_result = '0;
    alu_result = alu_result | ({XLEN{alu_op[0]}}  & (src1 + src2));
    alu_result = alu_result | ({XLEN{alu_op[1]}}  & (src1 - src2));
    alu_result = alu_result | ({XLEN{alu_op[2]}}  &
                               XLEN'($signed(src1) < $signed(src2)));
    alu_result = alu_result | ({XLEN{alu_op[3]}}  & XLEN'(src1 < src2));
    alu_result = alu_result | ({XLEN{alu_op[4]}}  & (src1 & src2));
    alu_result = alu_result | ({XLEN{alu_op[5]}}  & ~(src1 | src2));
    alu_result = alu_result | ({XLEN{alu_op[6]}}  & (src1 | src2));
    alu_result = alu_result | ({XLEN{alu_op[7]}}  & (src1 ^ src2));
    alu_result = alu_result | ({XLEN{alu_op[8]}}  & (src1 << shamt));
    alu_result = alu_result | ({XLEN{alu_op[9]}}  & (src1 >> shamt));
    alu_result = alu_result | ({XLEN{alu_op[10]}} &
                               XLEN'($signed(src1) >>> shamt));
    alu_result = alu_result | ({XLEN{alu_op[11]}} & {src2[19:0], 12'b0});
  end

  // Strobe only in the hand-off cycle so a stalled access is issued once
  assign data_sram_en    = !reset && es_valid && (load_op || mem_we) && ms_allowin;
  assign data_sram_we    = {4{!reset && es_valid && mem_we && ms_allowin}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

  assign es_to_ms_bus = {load_op, gr_we, dest, alu_result, pc};
  assign es_to_id_bus = {es_valid && gr_we, dest};

endmodule
